conv_pool_stage: RTL and testbench

- Streaming 2x2 max-pool stage sitting directly downstream of the 2D convolution engine.
- Consumes one convolution output word per accepted beat, in scan order, over an N x W output plane.
- Emits one pooled word per 2x2 window, together with its write address for the pooled-feature memory.
- No backpressure: the producer writes at up to one word per cycle, so this block accepts every valid beat.

---
 rtl/conv_pkg.sv | 23 ++
 rtl/pool_line_buf.sv | 26 ++
 rtl/conv_pool_stage.sv | 146 ++++++++++++++
 tb/tb_conv_pool_stage.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and default plane geometry for the convolution engine and
// the pooling stage that follows it.
package conv_pkg;

  typedef logic [15:0] data_t;

  typedef enum logic [1:0] {
    Idle = 2'd0,
    Even = 2'd1,
    Odd  = 2'd2
  } pool_phase_t;

  // Plane geometry shared with the convolution engine
  localparam int unsigned CONV_H = 32;
  localparam int unsigned CONV_R = 3;
  localparam int unsigned CONV_W = 32;
  localparam int unsigned CONV_N = 32;

  function automatic int unsigned pool_words(input int unsigned w, input int unsigned n);
    return (w / 2) * (n / 2);
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-line buffer holding the horizontal pair maxima of the last even line.
// One synchronous write port, one asynchronous read port, storage not reset.
module pool_line_buf #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned ABW   = 4
) (
  input  logic           clk_i,
  input  logic           we_i,
  input  logic [ABW-1:0] waddr_i,
  input  logic [DW-1:0]  wdata_i,
  input  logic [ABW-1:0] raddr_i,
  output logic [DW-1:0]  rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/conv_pool_stage.sv
// Streaming 2x2 max-pool stage fed in scan order by the convolution engine.
// Build option: CONV_POOL_RELU_EN clamps negative inputs to zero before pooling.
module conv_pool_stage
  import conv_pkg::*;
#(
  parameter int unsigned DW = 16,
  parameter int unsigned W  = CONV_W,
  parameter int unsigned N  = CONV_N,
  parameter int unsigned AW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          in_valid_i,
  input  logic [DW-1:0] in_data_i,
  output logic          out_valid_o,
  output logic [DW-1:0] out_data_o,
  output logic [AW-1:0] out_addr_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam int unsigned CW         = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned LW         = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned HALF_W     = W / 2;
  localparam int unsigned LBAW       = (HALF_W > 1) ? $clog2(HALF_W) : 1;
  localparam int unsigned POOL_WORDS = pool_words(W, N);

  if ((W % 2) != 0 || W < 2) begin : g_bad_w
    $error("conv_pool_stage: W must be even and non-zero");
  end
  if ((N % 2) != 0 || N < 2) begin : g_bad_n
    $error("conv_pool_stage: N must be even and non-zero");
  end
  if ((64'd1 << AW) < 64'(POOL_WORDS)) begin : g_bad_aw
    $error("conv_pool_stage: AW too narrow for the pooled plane");
  end

  function automatic logic [DW-1:0] smax(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  pool_phase_t   state_q;
  logic [CW-1:0] col_q;
  logic [LW-1:0] line_q;
  logic [DW-1:0] pair_q;
  logic [DW-1:0] x;
  logic [DW-1:0] lb_rdata;
  logic [DW-1:0] pair_max;
  logic [DW-1:0] win_max;
  logic [AW-1:0] addr_d;
  logic          accept;
  logic          col_last;
  logic          line_last;
  logic          lb_we;

`ifdef CONV_POOL_RELU_EN
  assign x = in_data_i[DW-1] ? '0 : in_data_i;
`else
  assign x = in_data_i;
`endif

  // start_i wins over a coincident beat, so such a beat is never accepted
  assign accept    = in_valid_i && !start_i && (state_q != Idle);
  assign col_last  = (col_q == CW'(W - 1));
  assign line_last = (line_q == LW'(N - 1));
  assign pair_max  = smax(pair_q, x);
  assign win_max   = smax(lb_rdata, pair_max);
  assign lb_we     = accept && (state_q == Even) && col_q[0];
  assign addr_d    = AW'(line_q >> 1) * AW'(HALF_W) + AW'(col_q >> 1);
  assign busy_o    = (state_q != Idle);

  pool_line_buf #(
    .DW   (DW),
    .DEPTH(HALF_W),
    .ABW  (LBAW)
  ) u_line_buf (
    .clk_i  (clk_i),
    .we_i   (lb_we),
    .waddr_i(LBAW'(col_q >> 1)),
    .wdata_i(pair_max),
    .raddr_i(LBAW'(col_q >> 1)),
    .rdata_o(lb_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i && accept && !col_q[0]) begin
      pair_q <= x;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= Idle;
      col_q       <= '0;
      line_q      <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_addr_o  <= '0;
      done_o      <= 1'b0;
    end else begin
      out_valid_o <= 1'b0;
      done_o      <= 1'b0;
      if (start_i) begin
        state_q <= Even;
        col_q   <= '0;
        line_q  <= '0;
      end else if (accept) begin
        if (state_q == Odd && col_q[0]) begin
          out_valid_o <= 1'b1;
          out_data_o  <= win_max;
          out_addr_o  <= addr_d;
        end
        if (!col_last) begin
          col_q <= col_q + 1'b1;
        end else begin
          col_q <= '0;
          unique case (state_q)
            Even: begin
              line_q  <= line_q + 1'b1;
              state_q <= Odd;
            end
            Odd: begin
              if (line_last) begin
                line_q  <= '0;
                state_q <= Idle;
                done_o  <= 1'b1;
              end else begin
                line_q  <= line_q + 1'b1;
                state_q <= Even;
              end
            end
            default: state_q <= Idle;
          endcase
        end
      end
    end
  end

  a_valid_idle: assert property (@(posedge clk_i) disable iff (rst_i)
    (out_valid_o && state_q == Idle) |-> done_o);

  a_addr_range: assert property (@(posedge clk_i) disable iff (rst_i)
    out_valid_o |-> (32'(out_addr_o) < POOL_WORDS));

endmodule

// File: tb/tb_conv_pool_stage.sv
// Directed bench for conv_pool_stage: a 4x4 instance for window-level cases
// and a default-geometry instance for the full 32x32 plane.
module tb_conv_pool_stage;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [15:0] in_data;

  logic        s_valid, s_busy, s_done;
  logic [15:0] s_data, s_addr;
  logic        d_valid, d_busy, d_done;
  logic [15:0] d_data, d_addr;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc    = 0;
  int unsigned drive_cyc;

  logic [15:0] s_data_q[$];
  logic [15:0] s_addr_q[$];
  int unsigned s_cyc_q[$];
  logic        s_done_q[$];
  int unsigned s_done_cnt = 0;
  logic [15:0] d_data_q[$];
  logic [15:0] d_addr_q[$];
  logic        d_done_q[$];
  int unsigned d_done_cnt = 0;

  conv_pool_stage #(.DW(16), .W(4), .N(4), .AW(16)) u_small (
    .clk_i(clk), .rst_i(rst), .start_i(start), .in_valid_i(in_valid), .in_data_i(in_data),
    .out_valid_o(s_valid), .out_data_o(s_data), .out_addr_o(s_addr),
    .busy_o(s_busy), .done_o(s_done)
  );

  conv_pool_stage #(.DW(16), .W(32), .N(32), .AW(16)) u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .in_valid_i(in_valid), .in_data_i(in_data),
    .out_valid_o(d_valid), .out_data_o(d_data), .out_addr_o(d_addr),
    .busy_o(d_busy), .done_o(d_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (s_valid === 1'b1) begin
      s_data_q.push_back(s_data);
      s_addr_q.push_back(s_addr);
      s_cyc_q.push_back(cyc);
      s_done_q.push_back(s_done);
    end
    if (s_done === 1'b1) s_done_cnt++;
    if (d_valid === 1'b1) begin
      d_data_q.push_back(d_data);
      d_addr_q.push_back(d_addr);
      d_done_q.push_back(d_done);
    end
    if (d_done === 1'b1) d_done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic st, input logic [15:0] d);
    in_valid  = v;
    start     = st;
    in_data   = d;
    drive_cyc = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0);
  endtask

  task automatic clear_logs();
    s_data_q.delete(); s_addr_q.delete(); s_cyc_q.delete(); s_done_q.delete();
    d_data_q.delete(); d_addr_q.delete(); d_done_q.delete();
    s_done_cnt = 0;
    d_done_cnt = 0;
  endtask

  // Ramp 0..n-1; with bubbles each beat is followed by one idle cycle
  task automatic send_ramp(input int unsigned n, input bit bubbles, output int unsigned bc[16]);
    for (int unsigned i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 16'(i));
      if (i < 16) bc[i] = drive_cyc;
      if (bubbles) step(1'b0, 1'b0, 16'hDEAD);
    end
  endtask

  task automatic check_small_ramp(input string tag, input bit chk_lat, input int unsigned bc[16]);
    logic [15:0] exp_val[4];
    int unsigned exp_idx[4];
    exp_val = '{16'd5, 16'd7, 16'd13, 16'd15};
    exp_idx = '{5, 7, 13, 15};
    check({tag, "_count"}, 32'(s_data_q.size()), 32'd4);
    for (int unsigned k = 0; k < 4; k++) begin
      if (k < s_data_q.size()) begin
        check($sformatf("%s_data%0d", tag, k), 32'(s_data_q[k]), 32'(exp_val[k]));
        check($sformatf("%s_addr%0d", tag, k), 32'(s_addr_q[k]), k);
        check($sformatf("%s_done%0d", tag, k), 32'(s_done_q[k]), (k == 3) ? 32'd1 : 32'd0);
        if (chk_lat)
          check($sformatf("%s_lat%0d", tag, k), s_cyc_q[k], bc[exp_idx[k]] + 1);
      end
    end
    check({tag, "_done_cnt"}, s_done_cnt, 32'd1);
    check({tag, "_idle_after"}, 32'(s_busy), 32'd0);
  endtask

  initial begin
    int unsigned bc[16];
    logic [15:0] neg[16];
    logic [15:0] neg_exp;

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    @(posedge clk); #1;

    // Reset with start and valid asserted
    step(1'b1, 1'b1, 16'h1234);
    rst = 1'b1;
    step(1'b1, 1'b1, 16'h1234);
    check("rst_valid", 32'(s_valid), 32'd0);
    check("rst_data", 32'(s_data), 32'd0);
    check("rst_addr", 32'(s_addr), 32'd0);
    check("rst_busy", 32'(s_busy), 32'd0);
    check("rst_done", 32'(s_done), 32'd0);
    check("rst_dflt_busy", 32'(d_busy), 32'd0);
    rst = 1'b0;
    clear_logs();
    for (int unsigned i = 0; i < 10; i++) step(1'b1, 1'b0, 16'(i));
    check("idle_no_out", 32'(s_data_q.size()), 32'd0);
    check("idle_busy", 32'(s_busy), 32'd0);

    // Ramp plane, back to back
    clear_logs();
    step(1'b0, 1'b1, 16'h0);
    check("start_busy", 32'(s_busy), 32'd1);
    send_ramp(16, 1'b0, bc);
    idle(4);
    check_small_ramp("ramp", 1'b1, bc);

    // Negative window
    neg = '{default: 16'h0000};
    neg[0] = 16'hFFF8; neg[1] = 16'hFFFD; neg[4] = 16'hFFFB; neg[5] = 16'hFFEC;
`ifdef CONV_POOL_RELU_EN
    neg_exp = 16'h0000;
`else
    neg_exp = 16'hFFFD;
`endif
    clear_logs();
    step(1'b0, 1'b1, 16'h0);
    for (int unsigned i = 0; i < 16; i++) step(1'b1, 1'b0, neg[i]);
    idle(4);
    check("neg_count", 32'(s_data_q.size()), 32'd4);
    if (s_data_q.size() > 0) check("neg_data0", 32'(s_data_q[0]), 32'(neg_exp));
    if (s_data_q.size() > 1) check("neg_data1", 32'(s_data_q[1]), 32'd0);

    // Bubbles
    clear_logs();
    step(1'b0, 1'b1, 16'h0);
    send_ramp(16, 1'b1, bc);
    idle(4);
    check_small_ramp("bubble", 1'b1, bc);

    // Mid-frame restart, coincident beat dropped
    step(1'b0, 1'b1, 16'h0);
    for (int unsigned i = 0; i < 9; i++) step(1'b1, 1'b0, 16'(16'h0100 + i));
    clear_logs();
    step(1'b1, 1'b1, 16'h7FFF);
    send_ramp(16, 1'b0, bc);
    idle(4);
    check_small_ramp("restart", 1'b0, bc);

    // Default geometry 32x32
    clear_logs();
    step(1'b0, 1'b1, 16'h0);
    for (int unsigned i = 0; i < 1024; i++) step(1'b1, 1'b0, 16'(i));
    idle(4);
    check("dflt_count", 32'(d_data_q.size()), 32'd256);
    for (int unsigned k = 0; k < 256; k++) begin
      if (k < d_data_q.size()) begin
        check($sformatf("dflt_data%0d", k), 32'(d_data_q[k]),
              (2 * (k / 16) + 1) * 32 + 2 * (k % 16) + 1);
        check($sformatf("dflt_addr%0d", k), 32'(d_addr_q[k]), k);
      end
    end
    if (d_done_q.size() == 256) check("dflt_done_last", 32'(d_done_q[255]), 32'd1);
    check("dflt_done_cnt", d_done_cnt, 32'd1);
    check("dflt_idle_after", 32'(d_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
